// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that feeds one shared serializer from N_REQ valid/ready requesters.
// One word is in flight at a time; the next grant waits until the serializer reports not busy.
module serializer_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int MOD_W    = 4,
    parameter int BUSY_LAT = 1
) (
    input  logic                      clk,
    input  logic                      i_srst,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ*MOD_W-1:0]    i_req_mod,
    input  logic [N_REQ-1:0]          i_req_val,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [DATA_W-1:0]         o_ser_data,
    output logic [MOD_W-1:0]          o_ser_mod,
    output logic                      o_ser_data_val,
    input  logic                      i_ser_busy,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id,
    output logic                      o_drop,
    output logic                      o_idle
);

    localparam int ID_W     = $clog2(N_REQ);
    localparam int CNT_W    = (BUSY_LAT > 2) ? $clog2(BUSY_LAT) : 1;
    localparam int LAT_LAST = (BUSY_LAT > 1) ? BUSY_LAT - 2 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, LAT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              transfer;
    logic              drop_word;
    logic [MOD_W-1:0]  win_mod;
    logic [CNT_W-1:0]  lat_cnt;

    // Search from ptr upward; ID_W-bit addition wraps because N_REQ is a power of two.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (!found && i_req_val[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && found) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    assign transfer       = |(i_req_val & o_req_ready);
    assign win_mod        = i_req_mod[winner*MOD_W +: MOD_W];
    assign drop_word      = (win_mod == MOD_W'(1)) || (win_mod == MOD_W'(2));
    assign o_ser_data_val = (state == ISSUE);
    assign o_idle         = (state == IDLE);

    // With BUSY_LAT == 1 the busy flag is already valid the cycle after the strobe,
    // so the LAT wait is skipped entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_nxt = drop_word ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = (BUSY_LAT > 1) ? LAT : DONE;
            end
            LAT: begin
                if (lat_cnt == CNT_W'(LAT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_ser_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            state      <= IDLE;
            ptr        <= '0;
            o_grant_id <= '0;
            o_ser_data <= '0;
            o_ser_mod  <= '0;
            o_drop     <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            state   <= state_nxt;
            o_drop  <= transfer && drop_word;
            lat_cnt <= (state == LAT) ? lat_cnt + CNT_W'(1) : '0;
            if (transfer) begin
                o_ser_data <= i_req_data[winner*DATA_W +: DATA_W];
                o_ser_mod  <= win_mod;
                o_grant_id <= winner;
                ptr        <= winner + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: requester sources, a behavioural serializer busy model
// and an event scoreboard, for one instance with BUSY_LAT=1 and one with BUSY_LAT=3.
module tb_serializer_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N*DW-1:0]   a_data, b_data;
    logic [N*MW-1:0]   a_mod, b_mod;
    logic [N-1:0]      a_val, b_val, a_ready, b_ready;
    logic [DW-1:0]     a_sdata, b_sdata;
    logic [MW-1:0]     a_smod, b_smod;
    logic              a_sval, b_sval, a_busy, b_busy;
    logic              a_drop, b_drop, a_idle, b_idle;
    logic [1:0]        a_gid, b_gid;

    serializer_arbiter #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW), .BUSY_LAT(1)) dut_a (
        .clk(clk), .i_srst(rst), .i_req_data(a_data), .i_req_mod(a_mod),
        .i_req_val(a_val), .o_req_ready(a_ready), .o_ser_data(a_sdata),
        .o_ser_mod(a_smod), .o_ser_data_val(a_sval), .i_ser_busy(a_busy),
        .o_grant_id(a_gid), .o_drop(a_drop), .o_idle(a_idle)
    );

    serializer_arbiter #(.N_REQ(N), .DATA_W(DW), .MOD_W(MW), .BUSY_LAT(3)) dut_b (
        .clk(clk), .i_srst(rst), .i_req_data(b_data), .i_req_mod(b_mod),
        .i_req_val(b_val), .o_req_ready(b_ready), .o_ser_data(b_sdata),
        .o_ser_mod(b_smod), .o_ser_data_val(b_sval), .i_ser_busy(b_busy),
        .o_grant_id(b_gid), .o_drop(b_drop), .o_idle(b_idle)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mod;
    } word_t;

    // kind: 0 = accepted transfer, 1 = issue strobe, 2 = drop pulse
    typedef struct {
        int          kind;
        int          id;
        logic [15:0] data;
        logic [3:0]  mod;
        logic        idle;
        int          cyc;
    } ev_t;

    word_t a_src[N][$];
    word_t b_src[N][$];
    ev_t   a_obs[$];
    ev_t   b_obs[$];
    ev_t   exp_q[$];

    int         cyc;
    int         n_checks;
    int         n_fail;
    logic [N-1:0] a_hs, b_hs;
    logic       a_st, b_st;
    int         a_cnt, b_cnt, a_len, b_len;
    logic [7:0] a_sh, b_sh;

    function automatic ev_t mk(int kind, int id, logic [15:0] d, logic [3:0] m);
        ev_t e;
        e.kind = kind; e.id = id; e.data = d; e.mod = m; e.idle = 1'b0; e.cyc = 0;
        return e;
    endfunction

    // One clock: update serializer models and requester drives after the edge,
    // then record DUT events on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        a_sh = {a_sh[6:0], a_st};
        b_sh = {b_sh[6:0], b_st};
        if (rst) begin
            a_cnt = 0; b_cnt = 0; a_sh = '0; b_sh = '0;
        end else begin
            if (a_sh[0]) a_cnt = a_len; else if (a_cnt > 0) a_cnt--;
            if (b_sh[2]) b_cnt = b_len; else if (b_cnt > 0) b_cnt--;
        end
        a_busy = (a_cnt != 0);
        b_busy = (b_cnt != 0);
        for (int k = 0; k < N; k++) begin
            if (a_hs[k]) void'(a_src[k].pop_front());
            if (b_hs[k]) void'(b_src[k].pop_front());
            if (a_src[k].size() > 0) begin
                a_data[k*DW +: DW] = a_src[k][0].data;
                a_mod[k*MW +: MW]  = a_src[k][0].mod;
                a_val[k] = 1'b1;
            end else begin
                a_val[k] = 1'b0;
            end
            if (b_src[k].size() > 0) begin
                b_data[k*DW +: DW] = b_src[k][0].data;
                b_mod[k*MW +: MW]  = b_src[k][0].mod;
                b_val[k] = 1'b1;
            end else begin
                b_val[k] = 1'b0;
            end
        end
        @(negedge clk);
        a_hs = a_val & a_ready;
        b_hs = b_val & b_ready;
        a_st = a_sval;
        b_st = b_sval;
        if (a_sval) a_obs.push_back('{kind: 1, id: int'(a_gid), data: a_sdata, mod: a_smod, idle: a_idle, cyc: cyc});
        if (a_drop) a_obs.push_back('{kind: 2, id: int'(a_gid), data: a_sdata, mod: a_smod, idle: a_idle, cyc: cyc});
        if (b_sval) b_obs.push_back('{kind: 1, id: int'(b_gid), data: b_sdata, mod: b_smod, idle: b_idle, cyc: cyc});
        if (b_drop) b_obs.push_back('{kind: 2, id: int'(b_gid), data: b_sdata, mod: b_smod, idle: b_idle, cyc: cyc});
        for (int k = 0; k < N; k++) begin
            if (a_hs[k]) a_obs.push_back('{kind: 0, id: k, data: a_src[k][0].data, mod: a_src[k][0].mod, idle: a_idle, cyc: cyc});
            if (b_hs[k]) b_obs.push_back('{kind: 0, id: k, data: b_src[k][0].data, mod: b_src[k][0].mod, idle: b_idle, cyc: cyc});
        end
    endtask

    task automatic run_a(int n, int budget);
        for (int i = 0; i < budget && a_obs.size() < n; i++) tick();
    endtask

    task automatic run_b(int n, int budget);
        for (int i = 0; i < budget && b_obs.size() < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        a_obs.delete();
        b_obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({a_idle, a_ready, a_sval, a_drop} !== 7'b1_0000_0_0) begin
                n_fail++;
                $display("FAIL reset_ctrl cyc%0d: got idle/ready/val/drop=%b, expected 1000000", i, {a_idle, a_ready, a_sval, a_drop});
            end
        end
        n_checks++;
        if ({a_sdata, a_smod, a_gid} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got data=%h mod=%h gid=%0d, expected all zero", a_sdata, a_smod, a_gid);
        end
        n_checks++;
        if ({b_idle, b_ready, b_sval, b_drop, b_sdata} !== {1'b1, 22'd0}) begin
            n_fail++;
            $display("FAIL reset_b: got idle=%b ready=%b val=%b data=%h, expected idle=1 rest 0", b_idle, b_ready, b_sval, b_sdata);
        end
    endtask

    task automatic test_single();
        ev_t o, e;
        int  c[4];
        do_reset();
        a_len = 16;
        a_src[0].push_back('{data: 16'hA5C3, mod: 4'd0});
        a_src[1].push_back('{data: 16'h1234, mod: 4'd5});
        exp_q.push_back(mk(0, 0, 16'hA5C3, 4'd0));
        exp_q.push_back(mk(1, 0, 16'hA5C3, 4'd0));
        exp_q.push_back(mk(0, 1, 16'h1234, 4'd5));
        exp_q.push_back(mk(1, 1, 16'h1234, 4'd5));
        run_a(4, 200);
        n_checks++;
        if (a_obs.size() != 4) begin
            n_fail++;
            $display("FAIL single_count: got %0d events, expected 4", a_obs.size());
        end
        for (int i = 0; i < 4; i++) begin
            c[i] = 0;
            if (a_obs.size() > 0) begin
                o = a_obs.pop_front(); e = exp_q.pop_front(); c[i] = o.cyc;
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL single_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        n_checks++;
        if (c[1] != c[0] + 1) begin
            n_fail++;
            $display("FAIL single_strobe_lat: got %0d cycles, expected 1", c[1] - c[0]);
        end
        n_checks++;
        if (c[2] != c[1] + 18) begin
            n_fail++;
            $display("FAIL single_next_xfer: got %0d cycles after strobe, expected 18", c[2] - c[1]);
        end
        n_checks++;
        if (c[3] != c[2] + 1) begin
            n_fail++;
            $display("FAIL single_strobe2_lat: got %0d cycles, expected 1", c[3] - c[2]);
        end
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        ev_t o, e;
        logic [15:0] d;
        do_reset();
        a_len = 4;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                d = 16'h1000 * k[15:0] + 16'h00A0 + r[15:0];
                a_src[k].push_back('{data: d, mod: 4'd4});
                exp_q.push_back(mk(0, k, d, 4'd4));
                exp_q.push_back(mk(1, k, d, 4'd4));
            end
        end
        run_a(16, 400);
        n_checks++;
        if (a_obs.size() != 16) begin
            n_fail++;
            $display("FAIL rr_count: got %0d events, expected 16", a_obs.size());
        end
        for (int i = 0; i < 16; i++) begin
            if (a_obs.size() > 0) begin
                o = a_obs.pop_front(); e = exp_q.pop_front();
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL rr_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        exp_q.delete();
        run_a(100, 20);
        a_obs.delete();
    endtask

    task automatic test_drop();
        ev_t o, e;
        int  c[4];
        logic idl[4];
        do_reset();
        a_src[2].push_back('{data: 16'hBEEF, mod: 4'd2});
        a_src[2].push_back('{data: 16'hCAFE, mod: 4'd1});
        exp_q.push_back(mk(0, 2, 16'hBEEF, 4'd2));
        exp_q.push_back(mk(2, 2, 16'hBEEF, 4'd2));
        exp_q.push_back(mk(0, 2, 16'hCAFE, 4'd1));
        exp_q.push_back(mk(2, 2, 16'hCAFE, 4'd1));
        run_a(4, 50);
        n_checks++;
        if (a_obs.size() != 4) begin
            n_fail++;
            $display("FAIL drop_count: got %0d events, expected 4", a_obs.size());
        end
        for (int i = 0; i < 4; i++) begin
            c[i] = 0; idl[i] = 1'b0;
            if (a_obs.size() > 0) begin
                o = a_obs.pop_front(); e = exp_q.pop_front(); c[i] = o.cyc; idl[i] = o.idle;
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL drop_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        n_checks++;
        if (c[1] != c[0] + 1 || c[3] != c[2] + 1) begin
            n_fail++;
            $display("FAIL drop_lat: got %0d and %0d cycles, expected 1 and 1", c[1] - c[0], c[3] - c[2]);
        end
        n_checks++;
        if (c[2] != c[1]) begin
            n_fail++;
            $display("FAIL drop_next_xfer: got %0d cycles after drop, expected 0", c[2] - c[1]);
        end
        n_checks++;
        if (idl[1] !== 1'b1 || idl[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_idle: got idle=%b,%b at drop, expected 1,1", idl[1], idl[3]);
        end
        tick();
        n_checks++;
        if (a_obs.size() != 0) begin
            n_fail++;
            $display("FAIL drop_extra: got %0d unexpected events, expected 0", a_obs.size());
        end
        exp_q.delete();
    endtask

    task automatic test_busy_low();
        ev_t o, e;
        int  c[4];
        // ptr is 3 after the dropped words from requester 2
        a_len = 0;
        a_src[1].push_back('{data: 16'h7777, mod: 4'd0});
        a_src[3].push_back('{data: 16'h3333, mod: 4'd3});
        exp_q.push_back(mk(0, 3, 16'h3333, 4'd3));
        exp_q.push_back(mk(1, 3, 16'h3333, 4'd3));
        exp_q.push_back(mk(0, 1, 16'h7777, 4'd0));
        exp_q.push_back(mk(1, 1, 16'h7777, 4'd0));
        run_a(4, 50);
        n_checks++;
        if (a_obs.size() != 4) begin
            n_fail++;
            $display("FAIL busylow_count: got %0d events, expected 4", a_obs.size());
        end
        for (int i = 0; i < 4; i++) begin
            c[i] = 0;
            if (a_obs.size() > 0) begin
                o = a_obs.pop_front(); e = exp_q.pop_front(); c[i] = o.cyc;
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL busylow_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        n_checks++;
        if (c[2] != c[1] + 2) begin
            n_fail++;
            $display("FAIL busylow_next_xfer: got %0d cycles after strobe, expected 2", c[2] - c[1]);
        end
        run_a(100, 5);
        n_checks++;
        if (a_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL busylow_idle: got idle=%b, expected 1", a_idle);
        end
        exp_q.delete();
        a_obs.delete();
    endtask

    task automatic test_lat3();
        ev_t o, e;
        int  c[4];
        do_reset();
        b_len = 8;
        b_src[0].push_back('{data: 16'hC3A5, mod: 4'd8});
        b_src[1].push_back('{data: 16'h5A5A, mod: 4'd8});
        exp_q.push_back(mk(0, 0, 16'hC3A5, 4'd8));
        exp_q.push_back(mk(1, 0, 16'hC3A5, 4'd8));
        exp_q.push_back(mk(0, 1, 16'h5A5A, 4'd8));
        exp_q.push_back(mk(1, 1, 16'h5A5A, 4'd8));
        run_b(4, 100);
        n_checks++;
        if (b_obs.size() != 4) begin
            n_fail++;
            $display("FAIL lat3_count: got %0d events, expected 4", b_obs.size());
        end
        for (int i = 0; i < 4; i++) begin
            c[i] = 0;
            if (b_obs.size() > 0) begin
                o = b_obs.pop_front(); e = exp_q.pop_front(); c[i] = o.cyc;
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL lat3_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        n_checks++;
        if (c[2] != c[1] + 12) begin
            n_fail++;
            $display("FAIL lat3_next_xfer: got %0d cycles after strobe, expected 12", c[2] - c[1]);
        end
        n_checks++;
        if (c[3] != c[1] + 13) begin
            n_fail++;
            $display("FAIL lat3_strobe_gap: got %0d cycles between strobes, expected 13", c[3] - c[1]);
        end
        exp_q.delete();
        run_b(100, 30);
        b_obs.delete();
    endtask

    task automatic test_reset_mid();
        ev_t o, e;
        do_reset();
        a_len = 16;
        a_src[1].push_back('{data: 16'h4321, mod: 4'd0});
        run_a(2, 20);
        tick(); tick(); tick();
        n_checks++;
        if (a_idle !== 1'b0 || a_sdata !== 16'h4321) begin
            n_fail++;
            $display("FAIL midrst_busy: got idle=%b data=%h, expected idle=0 data=4321", a_idle, a_sdata);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({a_idle, a_sdata, a_smod, a_gid, a_sval} !== {1'b1, 23'd0}) begin
            n_fail++;
            $display("FAIL midrst_state: got idle=%b data=%h mod=%h gid=%0d val=%b, expected idle=1 rest 0",
                     a_idle, a_sdata, a_smod, a_gid, a_sval);
        end
        rst = 1'b0;
        a_obs.delete();
        a_len = 2;
        a_src[3].push_back('{data: 16'h3333, mod: 4'd5});
        a_src[0].push_back('{data: 16'h0F0F, mod: 4'd6});
        exp_q.push_back(mk(0, 0, 16'h0F0F, 4'd6));
        exp_q.push_back(mk(1, 0, 16'h0F0F, 4'd6));
        exp_q.push_back(mk(0, 3, 16'h3333, 4'd5));
        exp_q.push_back(mk(1, 3, 16'h3333, 4'd5));
        run_a(4, 60);
        n_checks++;
        if (a_obs.size() != 4) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d events, expected 4", a_obs.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (a_obs.size() > 0) begin
                o = a_obs.pop_front(); e = exp_q.pop_front();
                n_checks++;
                if (o.kind !== e.kind || o.id !== e.id || o.data !== e.data || o.mod !== e.mod) begin
                    n_fail++;
                    $display("FAIL midrst_ev%0d: got kind=%0d id=%0d data=%h mod=%0d, expected kind=%0d id=%0d data=%h mod=%0d",
                             i, o.kind, o.id, o.data, o.mod, e.kind, e.id, e.data, e.mod);
                end
            end
        end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        a_data = '0; a_mod = '0; a_val = '0; a_busy = 1'b0;
        b_data = '0; b_mod = '0; b_val = '0; b_busy = 1'b0;
        a_hs = '0; b_hs = '0; a_st = 1'b0; b_st = 1'b0;
        a_cnt = 0; b_cnt = 0; a_len = 0; b_len = 0; a_sh = '0; b_sh = '0;
        cyc = 0; n_checks = 0; n_fail = 0;
        do_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_busy_low();
        test_lat3();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter that shares one `top_serializer` instance between `N_REQ` parallel-word requesters. Each requester offers a 16-bit word plus 4-bit bit-count modifier on a valid/ready handshake. The arbiter grants one word at a time, issues it to the serializer as a single-cycle `i_data_val` pulse, and holds all other requesters off until the serializer's `o_busy` falls. Sits directly in front of `top_serializer` (or `top_serializer_wrapper`, with `BUSY_LAT` raised to match).

## Interface
- `N_REQ`, 4: number of requesters; ≥2, power of two.
- `DATA_W`, 16: word width.
- `MOD_W`, 4: modifier width.
- `BUSY_LAT`, 1: cycles from `o_ser_data_val` to the first cycle `i_ser_busy` is valid; 3 for the wrapper.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `i_srst`  in  1  synchronous active-high reset.
- `i_req_data`  in  N_REQ*DATA_W  word per requester; requester k at bits [k*DATA_W +: DATA_W].
- `i_req_mod`  in  N_REQ*MOD_W  modifier per requester; same packing.
- `i_req_val`  in  N_REQ  requester k offers a word.
- `o_req_ready`  out  N_REQ  one-hot or zero; transfer on `val[k] & ready[k]`.
- `o_ser_data`  out  DATA_W  word to serializer.
- `o_ser_mod`  out  MOD_W  modifier to serializer.
- `o_ser_data_val`  out  1  one-cycle issue strobe.
- `i_ser_busy`  in  1  serializer busy.
- `o_grant_id`  out  $clog2(N_REQ)  index of the last accepted requester.
- `o_drop`  out  1  one-cycle pulse when an accepted word had mod 1 or 2.
- `o_idle`  out  1  high in IDLE.

## Operation
- States: IDLE, ISSUE, LAT, DONE.
- **IDLE:**
  - Winner = first requester with `val` high, searching from `ptr` upward with wrap.
  - `o_req_ready[winner]` = 1, combinational from `i_req_val` and `ptr`.
  - All other ready bits = 0. No requests means `o_req_ready` = 0.
- **On transfer:**
  - Capture data and mod into output registers.
  - `o_grant_id` ← winner.
  - `ptr` ← winner+1 (mod N_REQ).
  - If mod is 1 or 2, go to IDLE next cycle with `o_drop` = 1. The serializer ignores these words, so no strobe is issued.
  - Otherwise go to ISSUE.
- **ISSUE:** `o_ser_data_val` = 1 for exactly this cycle. Next state is LAT.
- **LAT:** count `BUSY_LAT`−1 further cycles, then go to DONE.
- **DONE:** stay while `i_ser_busy`=1. Go to IDLE on the first cycle `i_ser_busy`=0.
- `o_ser_data` and `o_ser_mod` hold their captured values until the next transfer.
- Mod 0 means 16 bits. Mod 3..15 means that many MSB-first bits. The arbiter does not interpret these values.
- `o_req_ready` = 0 in every state except IDLE.
- A requester's `val`, `data` and `mod` must stay stable until it sees ready. Dropping `val` before a grant is legal, and the arbiter re-evaluates each IDLE cycle.

## Timing
- **Reset values:**
  - `o_req_ready`=0, `o_ser_data`=0, `o_ser_mod`=0, `o_ser_data_val`=0.
  - `o_grant_id`=0, `o_drop`=0, `o_idle`=1.
  - `ptr`=0, state IDLE.
- **Reset mid-operation:** return to IDLE next cycle and discard the captured word. The serializer shares `i_srst`, so nothing is left pending.
- **Latency:**
  - Transfer at cycle t gives `o_ser_data_val` at t+1.
  - `i_ser_busy` is first sampled at t+1+`BUSY_LAT`.
  - The next transfer is possible in the cycle after busy is seen low.
- **Dropped word:** transfer at t, `o_drop` at t+1, next transfer possible at t+1.
- **Throughput:** one word per serialization plus `BUSY_LAT`+2 cycles of overhead.
- **Simultaneous requests:** resolved by `ptr`; each requester is served at most once per N_REQ grants while others wait.
- **Wrap-around:** grant at index N_REQ−1 sets `ptr`=0.
- **Busy low at the first sample:** covers the serializer rejecting the word or a 1-cycle job. Return to IDLE without hang.

## Test plan
- Reset, no requests, `i_ser_busy`=0 → `o_idle`=1, all outputs 0, no ready for 20 cycles.
- Req0 offers 0xA5C3 with mod 0. Serializer model holds busy 16 cycles → ready[0] at t, `o_ser_data_val` with 0xA5C3 at t+1, next ready no earlier than the cycle after busy falls.
- All four `val` held continuously, each with mod 4 → grant order 0,1,2,3,0,1. `o_grant_id` matches. Exactly one strobe per grant.
- Req2 offers mod 2 → ready[2] at t, `o_drop`=1 at t+1, no `o_ser_data_val`, back in IDLE at t+1.
- `BUSY_LAT`=3 against `top_serializer_wrapper` with mod 8 → no second strobe before the wrapper's `o_busy` returns low. Serial stream equals the top 8 bits MSB-first.
- `i_srst` asserted while in DONE → next cycle IDLE, `ptr`=0, `o_ser_data`=0. Req3 and req0 then pending → req0 is granted first.
